// File: rtl/spi_bit_sequencer.sv
// Serial sequencer for the 1-bit port of the SPI bit memory: shifts stored bits out on SDI
// (SPI mode 0) and optionally writes the sampled SDO back, with SEN/SLD framing and repeats.
//
// state    | meaning
// IDLE     | waiting for START
// PREFETCH | SEN up, reading address 0 (2 cycles)
// SHIFT    | 4 CLK per bit, SCLK high in ph2/ph3, write-back in ph3
// LOAD     | SLD strobe, SEN down
// WAIT     | inter-frame gap, then repeat or finish
module spi_bit_sequencer #(
    parameter int unsigned MEM_ABITS = 14
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 start_i,
    input  logic [MEM_ABITS:0]   size_i,
    input  logic [15:0]          wait_i,
    input  logic [7:0]           repeat_i,
    input  logic                 en_sdo_i,
    output logic [MEM_ABITS-1:0] mem_addr_o,
    input  logic                 mem_din_i,
    output logic                 mem_we_o,
    output logic                 mem_dout_o,
    output logic                 sclk_o,
    output logic                 sdi_o,
    input  logic                 sdo_i,
    output logic                 sen_o,
    output logic                 sld_o,
    output logic                 busy_o,
    output logic                 done_o
);
    localparam int unsigned SW = MEM_ABITS + 1;
    localparam logic [SW-1:0] DEPTH = {1'b1, {MEM_ABITS{1'b0}}};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREFETCH,
        ST_SHIFT,
        ST_LOAD,
        ST_WAIT
    } state_e;

    state_e               state_q, state_d;
    logic [1:0]           ph_q, ph_d;
    logic [SW-1:0]        bit_q, bit_d;
    logic [SW-1:0]        size_q, size_d;
    logic [15:0]          wait_q, wait_d;
    logic [15:0]          wcnt_q, wcnt_d;
    logic [7:0]           rep_q, rep_d;
    logic                 en_sdo_q, en_sdo_d;
    logic [MEM_ABITS-1:0] addr_q, addr_d;
    logic                 sdi_q, sdi_d;
    logic                 nxt_q, nxt_d;
    logic                 cap_q, cap_d;
    logic                 done_q, done_d;

    logic [SW-1:0]        size_eff;
    logic                 frame_end;
    logic                 wr_slot;

    assign size_eff = (size_i > DEPTH) ? DEPTH : size_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= ST_IDLE;
            ph_q     <= '0;
            bit_q    <= '0;
            size_q   <= '0;
            wait_q   <= '0;
            wcnt_q   <= '0;
            rep_q    <= '0;
            en_sdo_q <= 1'b0;
            addr_q   <= '0;
            sdi_q    <= 1'b0;
            nxt_q    <= 1'b0;
            cap_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ph_q     <= ph_d;
            bit_q    <= bit_d;
            size_q   <= size_d;
            wait_q   <= wait_d;
            wcnt_q   <= wcnt_d;
            rep_q    <= rep_d;
            en_sdo_q <= en_sdo_d;
            addr_q   <= addr_d;
            sdi_q    <= sdi_d;
            nxt_q    <= nxt_d;
            cap_q    <= cap_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ph_d      = ph_q;
        bit_d     = bit_q;
        size_d    = size_q;
        wait_d    = wait_q;
        wcnt_d    = wcnt_q;
        rep_d     = rep_q;
        en_sdo_d  = en_sdo_q;
        addr_d    = addr_q;
        sdi_d     = sdi_q;
        nxt_d     = nxt_q;
        cap_d     = cap_q;
        done_d    = done_q;
        frame_end = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    if (size_eff == '0) begin
                        done_d = 1'b1;
                    end else begin
                        size_d   = size_eff;
                        wait_d   = wait_i;
                        rep_d    = repeat_i;
                        en_sdo_d = en_sdo_i;
                        done_d   = 1'b0;
                        state_d  = ST_PREFETCH;
                        ph_d     = '0;
                        addr_d   = '0;
                    end
                end
            end
            ST_PREFETCH: begin
                if (ph_q == 2'd0) begin
                    ph_d = 2'd1;
                end else begin
                    state_d = ST_SHIFT;
                    ph_d    = '0;
                    bit_d   = '0;
                    sdi_d   = mem_din_i;
                    addr_d  = MEM_ABITS'(1);
                end
            end
            ST_SHIFT: begin
                ph_d = ph_q + 2'd1;
                case (ph_q)
                    2'd1: nxt_d = mem_din_i;
                    2'd2: begin
                        cap_d  = sdo_i;
                        addr_d = bit_q[MEM_ABITS-1:0];
                    end
                    2'd3: begin
                        // next bit's read address is (i+1)+1; wraps harmlessly after the last bit
                        bit_d  = bit_q + SW'(1);
                        addr_d = bit_q[MEM_ABITS-1:0] + MEM_ABITS'(2);
                        if (bit_q == size_q - SW'(1)) begin
                            state_d = ST_LOAD;
                            sdi_d   = 1'b0;
                        end else begin
                            sdi_d = nxt_q;
                        end
                    end
                    default: ;
                endcase
            end
            ST_LOAD: begin
                if (wait_q == 16'd0) begin
                    frame_end = 1'b1;
                end else begin
                    state_d = ST_WAIT;
                    wcnt_d  = wait_q - 16'd1;
                end
            end
            ST_WAIT: begin
                if (wcnt_q == 16'd0) begin
                    frame_end = 1'b1;
                end else begin
                    wcnt_d = wcnt_q - 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (frame_end) begin
            if (rep_q != 8'd0) begin
                rep_d   = rep_q - 8'd1;
                state_d = ST_PREFETCH;
                ph_d    = '0;
                addr_d  = '0;
            end else begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
        end
    end

    assign wr_slot    = (state_q == ST_SHIFT) && (ph_q == 2'd3);
    assign mem_addr_o = addr_q;
    assign mem_we_o   = wr_slot & en_sdo_q;
    assign mem_dout_o = wr_slot & cap_q;
    assign sclk_o     = (state_q == ST_SHIFT) && ph_q[1];
    assign sdi_o      = sdi_q;
    assign sen_o      = (state_q == ST_PREFETCH) || (state_q == ST_SHIFT);
    assign sld_o      = (state_q == ST_LOAD);
    assign busy_o     = (state_q != ST_IDLE);
    assign done_o     = done_q;

endmodule
